// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select input of a NUM_LEVELS-deep mux tree.
// A grant is held while its requester keeps asking, for at most BURST cycles.
module mux_rr_arbiter #(
   parameter int NUM_LEVELS = 5,
   parameter int WIDTH      = 2**(NUM_LEVELS-1),
   parameter int BURST      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        req,
   output logic [NUM_LEVELS-2:0]   sel,
   output logic [WIDTH-1:0]        grant,
   output logic                    valid
);

   localparam int SW = NUM_LEVELS - 1;
   localparam int CW = $clog2(BURST + 1);
   localparam logic [SW:0]   WIDTH_W = (SW+1)'(WIDTH);
   localparam logic [CW-1:0] BURST_C = CW'(BURST);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_reg;
   logic [SW-1:0]   ptr_reg;
   logic [CW-1:0]   cnt_reg;

   logic [SW-1:0]   next_ptr;
   logic [SW-1:0]   arb_ptr;
   logic [WIDTH-1:0] rot_req;
   logic [SW-1:0]   rot_idx [WIDTH];
   logic            win_found;
   logic [SW-1:0]   win_idx;
   logic            rel;

   // On release the search restarts just past the current owner, in the same edge.
   assign next_ptr = (sel == SW'(WIDTH - 1)) ? '0 : sel + SW'(1);
   assign arb_ptr  = (state_reg == GRANT) ? next_ptr : ptr_reg;
   assign rel      = !req[sel] || (cnt_reg == BURST_C);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_rot
         logic [SW:0] sum;
         assign sum          = {1'b0, arb_ptr} + (SW+1)'(gi);
         assign rot_idx[gi]  = (sum >= WIDTH_W) ? SW'(sum - WIDTH_W) : SW'(sum);
         assign rot_req[gi]  = req[rot_idx[gi]];
      end
   endgenerate

   // Lowest rotated offset wins, i.e. first requester at or after arb_ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (rot_req[i]) begin
            win_found = 1'b1;
            win_idx   = rot_idx[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         sel       <= '0;
         grant     <= '0;
         valid     <= 1'b0;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  state_reg <= GRANT;
                  sel       <= win_idx;
                  grant     <= WIDTH'(1) << win_idx;
                  valid     <= 1'b1;
                  cnt_reg   <= CW'(1);
               end
            end
            GRANT: begin
               if (!rel) begin
                  cnt_reg <= cnt_reg + CW'(1);
               end else begin
                  ptr_reg <= next_ptr;
                  if (win_found) begin
                     sel     <= win_idx;
                     grant   <= WIDTH'(1) << win_idx;
                     cnt_reg <= CW'(1);
                  end else begin
                     state_reg <= IDLE;
                     grant     <= '0;
                     valid     <= 1'b0;
                     cnt_reg   <= '0;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               grant     <= '0;
               valid     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter with 4 requesters and a burst limit of 2.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       valid;

   mux_rr_arbiter #(.NUM_LEVELS(3), .WIDTH(4), .BURST(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .sel   (sel),
      .grant (grant),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [1:0] sel;
      logic [3:0] grant;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   logic       m_valid;
   logic [1:0] m_sel;
   logic [1:0] m_ptr;
   int         m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
   endtask

   function automatic int find_winner(input logic [1:0] p, input logic [3:0] r);
      for (int off = 0; off < 4; off++) begin
         if (r[(int'(p) + off) % 4]) return (int'(p) + off) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_sel   = 2'd0;
      m_ptr   = 2'd0;
      m_cnt   = 0;
   endtask

   task automatic model_step(input logic [3:0] r);
      int w;
      if (!m_valid) begin
         w = find_winner(m_ptr, r);
         if (w >= 0) begin
            m_valid = 1'b1;
            m_sel   = 2'(w);
            m_cnt   = 1;
         end
      end else if (r[m_sel] && m_cnt < 2) begin
         m_cnt++;
      end else begin
         m_ptr = 2'((int'(m_sel) + 1) % 4);
         w = find_winner(m_ptr, r);
         if (w >= 0) begin
            m_sel = 2'(w);
            m_cnt = 1;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Drive one request pattern, push the expectation, compare after the edge.
   task automatic step(input string tag, input logic [3:0] r);
      exp_t e;
      exp_t got;
      @(negedge clk);
      req = r;
      model_step(r);
      e.valid = m_valid;
      e.sel   = m_sel;
      e.grant = m_valid ? (4'b0001 << m_sel) : 4'b0000;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      $display("%0t %s req=%b -> valid=%b sel=%0d grant=%b", $time, tag, r, valid, sel, grant);
      check({tag, "_valid"}, 32'(valid), 32'(got.valid));
      check({tag, "_sel"},   32'(sel),   32'(got.sel));
      check({tag, "_grant"}, 32'(grant), 32'(got.grant));
      check({tag, "_onehot"}, 32'($onehot0(grant)), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 4'b1111;
      #1;
      check("rst_async_valid", 32'(valid), 32'd0);
      check("rst_async_grant", 32'(grant), 32'd0);
      check("rst_async_sel",   32'(sel),   32'd0);
      @(posedge clk);
      #1;
      check("rst_edge_valid", 32'(valid), 32'd0);
      check("rst_edge_grant", 32'(grant), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0000;
      model_reset();
   endtask

   logic [1:0] cont_sel [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      model_reset();
      #12;

      // Reset with every requester asking
      do_reset();

      // Single requester keeps the grant through burst re-arbitration
      for (int i = 0; i < 5; i++) begin
         step("single", 4'b0100);
         check("single_sel_const", 32'(sel), 32'd2);
         check("single_valid_const", 32'(valid), 32'd1);
      end
      step("single_drop", 4'b0000);

      // Full contention from a fresh pointer
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step("contend", 4'b1111);
         check("contend_seq", 32'(sel), 32'(cont_sel[i]));
      end
      step("contend_drop", 4'b0000);

      // Early release
      step("early", 4'b0010);
      check("early_sel", 32'(sel), 32'd1);
      step("early_idle", 4'b0000);
      check("early_idle_grant", 32'(grant), 32'd0);
      check("early_idle_sel",   32'(sel),   32'd1);
      step("early_idle2", 4'b0000);

      // Wrap-around after releasing index 2
      step("wrap_a", 4'b0100);
      check("wrap_a_sel", 32'(sel), 32'd2);
      step("wrap_b", 4'b0011);
      check("wrap_b_sel", 32'(sel), 32'd0);
      step("wrap_c", 4'b0011);
      step("wrap_d", 4'b0011);
      check("wrap_d_sel", 32'(sel), 32'd1);
      step("wrap_end", 4'b0000);
      step("wrap_end2", 4'b0000);

      // Asynchronous reset in the middle of a grant to index 3
      do_reset();
      step("mid_a", 4'b1000);
      check("mid_a_sel", 32'(sel), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_valid", 32'(valid), 32'd0);
      @(posedge clk);
      #1;
      check("mid_rst_hold", 32'(valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step("mid_after", 4'b1000);
      check("mid_after_grant", 32'(grant), 32'b1000);

      // Random traffic against the model
      for (int i = 0; i < 60; i++) begin
         step("rand", 4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_LEVELS, default 5, the number of levels of the Mux tree being controlled.
REQ-002 The module SHALL have parameter WIDTH, default 2**(NUM_LEVELS-1), the number of requesters, equal to the Mux input count.
REQ-003 The module SHALL have parameter BURST, default 4, the maximum number of consecutive cycles one grant may be held (BURST >= 1).
REQ-004 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port req, input, WIDTH bits: requester i asserts req[i] while it wants the shared Mux output.
REQ-007 Port sel, output, NUM_LEVELS-1 bits: registered binary index of the granted requester; it drives the Mux sel input directly.
REQ-008 Port grant, output, WIDTH bits: registered one-hot grant; all zero when nothing is granted.
REQ-009 Port valid, output, 1 bit: registered; high while a grant is active, which means the Mux output is owned.

Function
REQ-010 The FSM SHALL have two states, IDLE and GRANT; valid SHALL be 1 exactly when the state is GRANT.
REQ-011 Internal state SHALL consist of a round-robin pointer ptr (NUM_LEVELS-1 bits) and a hold counter cnt (width clog2(BURST+1)).
REQ-012 Arbitration winner: the lowest index k >= ptr with req[k]=1, searched modulo WIDTH (wrap past WIDTH-1 to 0).
REQ-013 In IDLE, if req has any bit set at a rising edge, the block SHALL go to GRANT with sel=winner, grant=one-hot(winner), cnt=1. Latency is one cycle from req to grant.
REQ-014 In IDLE with req=0, all state SHALL hold and grant SHALL stay zero.
REQ-015 In GRANT, at each edge the release condition SHALL be (req[sel]==0) or (cnt==BURST). If not released, the block SHALL increment cnt and hold sel and grant.
REQ-016 On release, ptr SHALL become sel+1 modulo WIDTH, and arbitration SHALL be re-run in the same edge using the new ptr.
REQ-017 If a winner exists on release, the block SHALL stay in GRANT with the new sel, grant, and cnt=1, with no idle bubble. This winner may be the same requester when it is the only one pending.
REQ-018 If no winner exists on release, the block SHALL go to IDLE with grant=0; sel SHALL hold its last value.
REQ-019 grant SHALL never have more than one bit set, and grant[sel] SHALL be 1 whenever valid=1.
REQ-020 req bits that change between edges SHALL have no effect until the next rising edge. There are no combinational paths from req to any output.
REQ-021 A requester whose req drops in the same cycle its grant would start SHALL not be granted, because the winner is computed from req sampled at the edge.

Reset
REQ-022 While rst=1, the block SHALL immediately (asynchronously) set state=IDLE, sel=0, grant=0, valid=0, ptr=0, cnt=0, regardless of the clock.
REQ-023 Reset asserted mid-grant SHALL drop the grant at once. After rst falls, the first arbitration SHALL start from ptr=0.

Verification (NUM_LEVELS=3, WIDTH=4, BURST=2)
REQ-024 Reset check: rst pulsed high with req=1111 -> sel=0, grant=0000, valid=0 during reset, and no grant on the edge coincident with reset.
REQ-025 Single requester: req=0100 held -> one edge later valid=1, sel=2, grant=0100. valid stays continuously 1, with cnt cycling 1,2,1,2 and sel=2 throughout.
REQ-026 Full contention: req=1111 held -> sel sequence 0,0,1,1,2,2,3,3,0,0 with no idle cycle and grant always one-hot.
REQ-027 Early release: req=0010 for one cycle only -> valid=1, sel=1 for exactly one cycle, then IDLE with grant=0000 and sel held at 1.
REQ-028 Wrap-around: after a grant to index 2 is released with req=0011 -> next grant sel=0 (ptr=3, search wraps), then sel=1.
REQ-029 Reset mid-operation: rst asserted asynchronously during a grant to index 3 -> grant=0000 and valid=0 before the next clock edge. After release with req=1000 -> grant to index 3 one edge later.
